pool_flatten_engine: RTL and testbench
======================================

Name: pool_flatten_engine

Overview:
- Layer-1/Layer-2 stage of the CONV accelerator. Sits directly downstream of the layer-0 convolution engine.
- Once layer 0 has filled both 64x64 L0 memories, the block reads them and performs 2x2 stride-2 max pooling into the two 32x32 L1 memories.
- In the same pass it writes the kernel-interleaved flatten output into the 2048-entry L2 memory.
- It shares the cwr/crd/csel memory bus with the conv engine. The top-level controller grants the bus only while this block is busy.

Parameters:
- IN_W, 64, L0 feature-map width/height (power of 2).
- DATA_W, 20, pixel width.
- ADDR_W, 12, memory address width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous active-low reset (asserted when 0).
- start  in  1  single-cycle request to begin; sampled only in IDLE.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the final L2 write.
- crd  out  1  memory read strobe.
- caddr_rd  out  ADDR_W  read address.
- cdata_rd  in  DATA_W  read data. Memory samples csel/caddr_rd on the falling edge and drives data valid for the next rising edge.
- cwr  out  1  memory write strobe, sampled with caddr_wr/cdata_wr/csel on the rising edge.
- caddr_wr  out  ADDR_W  write address.
- cdata_wr  out  DATA_W  write data.
- csel  out  3  memory select: 001 L0 k0, 010 L0 k1, 011 L1 k0, 100 L1 k1, 101 L2. 000 when idle.

Behaviour:
- Reset (reset=0, asynchronous):
  - busy, done, crd and cwr go to 0.
  - csel, caddr_rd, caddr_wr and cdata_wr go to 0.
  - FSM goes to IDLE; row/column/kernel counters and the running-max register clear.
- Reset mid-operation: the pass is abandoned. After release the block waits in IDLE for a new start. Nothing resumes.
- Iteration order: output row r 0..31 (outer), column c 0..31, kernel k 0..1 (inner).
- Per (r,c,k) the FSM steps through 7 states, one cycle each:
  - RD0: crd=1, csel=L0 k, caddr_rd=(2r)*IN_W+2c.
  - RD1: crd=1, caddr_rd=(2r)*IN_W+2c+1; max<=cdata_rd.
  - RD2: crd=1, caddr_rd=(2r+1)*IN_W+2c; max<=max(max,cdata_rd).
  - RD3: crd=1, caddr_rd=(2r+1)*IN_W+2c+1; max<=max(max,cdata_rd).
  - MAX: crd=0, csel held; max<=max(max,cdata_rd).
  - WL1: cwr=1, csel=011+k, caddr_wr=r*32+c, cdata_wr=max.
  - WL2: cwr=1, csel=101, caddr_wr=(r*32+c)*2+k, cdata_wr=max.
- Sequencing: after WL2, advance k, then c, then r, and return to RD0. After WL2 of (31,31,1), go to DONE.
- DONE lasts one cycle: done=1, busy=0, then IDLE. busy is 1 in every state except IDLE and DONE.
- Fixed cost: 7 cycles per output, 2048 outputs = 14336 busy cycles, plus 1 DONE cycle.
- Compare rule: unsigned DATA_W-bit compare. Inputs are post-ReLU, so non-negative. Ties keep either value (identical bits). No rounding or saturation; output equals one of the four inputs bit-exactly.
- Bus exclusivity: crd and cwr are never both 1. cwr=0 in RD*/MAX; crd=0 in WL*.
- Outputs in states where they are unused hold their last value, except crd and cwr, which are 0.
- start while busy: ignored, with no effect on counters.
- start in the same cycle as DONE: ignored. A new start is accepted the following cycle in IDLE.
- Counter wrap: c wraps 31->0 with r increment. r=31,c=31,k=1 terminates; it never wraps to 0 while busy.
- All outputs are registered; none is combinational from cdata_rd or start.

Test Plan:
- L0 k0 all 0x00000, L0 k1 all 0xFFFFF, start -> L1 k0 all 0x00000, L1 k1 all 0xFFFFF. L2[even]=0, L2[odd]=0xFFFFF. done exactly 14337 cycles after start accepted.
- Single nonzero 0x12345 placed in each window position in turn (L0 k0 addr 0, 1, 64, 65) -> L1 k0[0]=0x12345 and L2[0]=0x12345 each run; all other outputs 0.
- Window {0x00010,0x80000,0x7FFFF,0x00001} at r=5,c=7 -> L1[167]=0x80000 and L2[334] (k0) or L2[335] (k1) = 0x80000 (unsigned compare).
- Random 20-bit non-negative L0 images vs reference model -> all 1024+1024+2048 words match. The monitor also checks crd&cwr never both 1 and the per-output address/csel sequence is exact.
- start pulsed again at cycles 100 and 5000 of a pass -> no restart; cycle count and results unchanged.
- reset driven 0 mid-pass (cycle 3000) -> all outputs 0 immediately, busy=0. A new start then produces a full correct pass.

Source files
------------

// File: rtl/pool_flatten_engine.sv
// Purpose : 2x2 stride-2 max pooling of two L0 maps into two L1 maps, plus kernel-interleaved L2 flatten.
// Latency : 7 cycles per pooled output (4 reads, 1 max, 2 writes); 2048 outputs, then a 1-cycle done pulse.
// Backpressure: none. Owns the shared memory bus while busy; start is ignored unless idle.
//
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-low reset
//   start         single-cycle request, sampled only in IDLE
//   busy, done    busy from the cycle after start until the last output; done pulses for one cycle after it
//   crd/caddr_rd  read strobe and address; cdata_rd returns one cycle later (memory samples on falling edge)
//   cwr/caddr_wr/cdata_wr  write strobe, address and data
//   csel          001 L0 k0, 010 L0 k1, 011 L1 k0, 100 L1 k1, 101 L2, 000 idle
module pool_flatten_engine #(
  parameter int IN_W   = 64,
  parameter int DATA_W = 20,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        csel
);

  localparam int IW = $clog2(IN_W);
  localparam int CW = IW - 1;

  localparam logic [2:0] SEL_IDLE = 3'b000;
  localparam logic [2:0] SEL_L0K0 = 3'b001;
  localparam logic [2:0] SEL_L0K1 = 3'b010;
  localparam logic [2:0] SEL_L1K0 = 3'b011;
  localparam logic [2:0] SEL_L1K1 = 3'b100;
  localparam logic [2:0] SEL_L2   = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_MAX, S_WL1, S_WL2, S_DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     row;
  logic [CW-1:0]     col;
  logic              ker;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] max_nxt;

  // Window addresses: the feature-map width is a power of two, so
  // (2r+dy)*IN_W + 2c+dx is just a bit concatenation.
  logic [2*IW-1:0] a0, a1, a2, a3;
  logic [2*CW-1:0] pix;

  assign a0  = {row, 1'b0, col, 1'b0};
  assign a1  = {row, 1'b0, col, 1'b1};
  assign a2  = {row, 1'b1, col, 1'b0};
  assign a3  = {row, 1'b1, col, 1'b1};
  assign pix = {row, col};

  // Inputs are post-ReLU, so a plain unsigned compare is exact.
  assign max_nxt = (cdata_rd > max_q) ? cdata_rd : max_q;

  // Each state registers the bus values it owns, so they appear on the bus
  // one cycle later. Read data therefore arrives two states after its address
  // was issued: RD0's address is captured in RD1 ... RD3's in MAX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      csel     <= SEL_IDLE;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      row      <= '0;
      col      <= '0;
      ker      <= 1'b0;
      max_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          crd  <= 1'b0;
          cwr  <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state <= S_RD0;
            busy  <= 1'b1;
            row   <= '0;
            col   <= '0;
            ker   <= 1'b0;
          end
        end
        S_RD0: begin
          cwr      <= 1'b0;
          crd      <= 1'b1;
          csel     <= ker ? SEL_L0K1 : SEL_L0K0;
          caddr_rd <= ADDR_W'(a0);
          state    <= S_RD1;
        end
        S_RD1: begin
          caddr_rd <= ADDR_W'(a1);
          max_q    <= cdata_rd;
          state    <= S_RD2;
        end
        S_RD2: begin
          caddr_rd <= ADDR_W'(a2);
          max_q    <= max_nxt;
          state    <= S_RD3;
        end
        S_RD3: begin
          caddr_rd <= ADDR_W'(a3);
          max_q    <= max_nxt;
          state    <= S_MAX;
        end
        S_MAX: begin
          crd   <= 1'b0;
          max_q <= max_nxt;
          state <= S_WL1;
        end
        S_WL1: begin
          cwr      <= 1'b1;
          csel     <= ker ? SEL_L1K1 : SEL_L1K0;
          caddr_wr <= ADDR_W'(pix);
          cdata_wr <= max_q;
          state    <= S_WL2;
        end
        S_WL2: begin
          csel     <= SEL_L2;
          caddr_wr <= ADDR_W'({pix, ker});
          state    <= S_RD0;
          // Kernel is the fastest index, then column, then row.
          if (!ker) begin
            ker <= 1'b1;
          end else begin
            ker <= 1'b0;
            if (&col) begin
              col <= '0;
              if (&row) begin
                // The final L2 write is still on the bus during DONE.
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          cwr   <= 1'b0;
          csel  <= SEL_IDLE;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_flatten_engine.sv
// Purpose : directed bench for pool_flatten_engine with a bus-level memory model.
// Latency : full passes of 14336 busy cycles plus one done cycle.
// Backpressure: none; the memory model answers every read the following cycle.
module tb_pool_flatten_engine;
  localparam int IN_W   = 64;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy, done, crd, cwr;
  logic [ADDR_W-1:0] caddr_rd, caddr_wr;
  logic [DATA_W-1:0] cdata_rd = '0;
  logic [DATA_W-1:0] cdata_wr;
  logic [2:0]        csel;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] l0 [2][IN_W*IN_W];
  logic [DATA_W-1:0] l1 [2][1024];
  logic [DATA_W-1:0] l2 [2048];

  int rd_idx, wr_idx, seq_err, both_err;
  int bcyc, tcyc, first_busy;
  bit got_done;

  pool_flatten_engine #(.IN_W(IN_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  always #5 clk = ~clk;

  // Memory model and bus monitor, on the falling edge (memory sampling point).
  always @(negedge clk) begin
    int o, w, k, p, r, c, ea;
    if (crd && cwr) both_err++;
    if (crd) begin
      o = rd_idx >> 2; w = rd_idx & 3; k = o & 1; p = o >> 1; r = p >> 5; c = p & 31;
      ea = (2*r + (w >> 1)) * IN_W + 2*c + (w & 1);
      if (rd_idx >= 8192 || int'(caddr_rd) != ea || int'(csel) != 1 + k) seq_err++;
      if (csel == 3'd1)      cdata_rd = l0[0][caddr_rd];
      else if (csel == 3'd2) cdata_rd = l0[1][caddr_rd];
      rd_idx++;
    end
    if (cwr) begin
      o = wr_idx >> 1; k = o & 1; p = o >> 1;
      if (wr_idx >= 4096) seq_err++;
      else if ((wr_idx & 1) == 0) begin
        if (int'(csel) != 3 + k || int'(caddr_wr) != p) seq_err++;
      end else begin
        if (csel != 3'd5 || int'(caddr_wr) != 2*p + k) seq_err++;
      end
      case (csel)
        3'd3:    l1[0][caddr_wr[9:0]] = cdata_wr;
        3'd4:    l1[1][caddr_wr[9:0]] = cdata_wr;
        3'd5:    l2[caddr_wr[10:0]]   = cdata_wr;
        default: seq_err++;
      endcase
      wr_idx++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_const(input logic [DATA_W-1:0] v0, input logic [DATA_W-1:0] v1);
    for (int i = 0; i < IN_W*IN_W; i++) begin
      l0[0][i] = v0;
      l0[1][i] = v1;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < IN_W*IN_W; i++) begin
      l0[0][i] = DATA_W'($urandom);
      l0[1][i] = DATA_W'($urandom);
    end
  endtask

  // Runs one pass; pa/pb are cycles with an extra start pulse, abort_at pulls reset.
  task automatic run_pass(input int pa, input int pb, input int abort_at);
    rd_idx = 0; wr_idx = 0; seq_err = 0; both_err = 0;
    bcyc = 0; tcyc = 0; got_done = 0; first_busy = 0;
    for (int i = 0; i < 1024; i++) begin l1[0][i] = 'x; l1[1][i] = 'x; end
    for (int i = 0; i < 2048; i++) l2[i] = 'x;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 1; n <= 20000; n++) begin
      if (n == 1) first_busy = int'(busy);
      if (busy) bcyc++;
      if (busy || done) tcyc++;
      if (done) begin got_done = 1; break; end
      if (n == abort_at) begin reset = 1'b0; break; end
      start = (n == pa || n == pb);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // Reference: max of each 2x2 window, checked against all L1 and L2 words.
  task automatic check_results(input string tag);
    int e1, e2;
    logic [DATA_W-1:0] m, v;
    e1 = 0; e2 = 0;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++) begin
          m = l0[k][(2*r)*IN_W + 2*c];
          v = l0[k][(2*r)*IN_W + 2*c + 1];     if (v > m) m = v;
          v = l0[k][(2*r+1)*IN_W + 2*c];       if (v > m) m = v;
          v = l0[k][(2*r+1)*IN_W + 2*c + 1];   if (v > m) m = v;
          if (l1[k][r*32 + c] !== m) e1++;
          if (l2[(r*32 + c)*2 + k] !== m) e2++;
        end
    chk({tag, "_l1_bad_words"}, e1, 0);
    chk({tag, "_l2_bad_words"}, e2, 0);
  endtask

  task automatic check_pass(input string tag);
    chk({tag, "_done_seen"}, got_done, 1);
    chk({tag, "_first_busy"}, first_busy, 1);
    chk({tag, "_busy_cycles"}, bcyc, 14336);
    chk({tag, "_total_cycles"}, tcyc, 14337);
    @(negedge clk);
    chk({tag, "_idle_after"}, {busy, done, crd, cwr, csel}, 0);
    chk({tag, "_reads"}, rd_idx, 8192);
    chk({tag, "_writes"}, wr_idx, 4096);
    chk({tag, "_seq_err"}, seq_err, 0);
    chk({tag, "_rd_wr_overlap"}, both_err, 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    #1;
    chk("reset_outputs", {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}, 0);
    repeat (3) @(negedge clk);
    chk("reset_outputs_clocked", {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_start", {busy, done, crd, cwr}, 0);

    // Constant maps: k0 all zero, k1 all ones.
    fill_const(20'h00000, 20'hFFFFF);
    run_pass(0, 0, 0);
    check_pass("const");
    chk("const_l1k0_5", l1[0][5], 20'h00000);
    chk("const_l1k1_1023", l1[1][1023], 20'hFFFFF);
    chk("const_l2_0", l2[0], 20'h00000);
    chk("const_l2_2047", l2[2047], 20'hFFFFF);
    check_results("const");

    // Lone 0x12345 in each window position (windows (0,0),(0,1),(1,0),(1,1)),
    // plus an unsigned-compare window at r=5,c=7 in both kernels.
    fill_const(20'h00000, 20'h00000);
    l0[0][0]   = 20'h12345;
    l0[0][3]   = 20'h12345;
    l0[0][192] = 20'h12345;
    l0[0][195] = 20'h12345;
    l0[1][654] = 20'h00010; l0[1][655] = 20'h80000;
    l0[1][718] = 20'h7FFFF; l0[1][719] = 20'h00001;
    l0[0][654] = 20'h7FFFF; l0[0][655] = 20'h00001;
    l0[0][718] = 20'h80000; l0[0][719] = 20'h00010;
    run_pass(0, 0, 0);
    check_pass("directed");
    chk("pos0_l1", l1[0][0],  20'h12345);
    chk("pos0_l2", l2[0],     20'h12345);
    chk("pos1_l1", l1[0][1],  20'h12345);
    chk("pos1_l2", l2[2],     20'h12345);
    chk("pos2_l1", l1[0][32], 20'h12345);
    chk("pos2_l2", l2[64],    20'h12345);
    chk("pos3_l1", l1[0][33], 20'h12345);
    chk("pos3_l2", l2[66],    20'h12345);
    chk("k1_of_pos0_l2", l2[1], 20'h00000);
    chk("neighbour_l1k0_2", l1[0][2], 20'h00000);
    chk("ucmp_l1k0_167", l1[0][167], 20'h80000);
    chk("ucmp_l1k1_167", l1[1][167], 20'h80000);
    chk("ucmp_l2_334", l2[334], 20'h80000);
    chk("ucmp_l2_335", l2[335], 20'h80000);
    check_results("directed");

    // Random maps, with start pulsed again mid-pass.
    fill_rand();
    run_pass(100, 5000, 0);
    check_pass("rand_restart");
    check_results("rand_restart");

    // Reset mid-pass: outputs clear at once and nothing resumes.
    fill_rand();
    run_pass(0, 0, 3000);
    #1;
    chk("abort_outputs", {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_stays_idle", {busy, done, crd, cwr, csel}, 0);
    run_pass(0, 0, 0);
    check_pass("after_abort");
    check_results("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
